// File: rtl/addr_cal_phase2_param.sv
// Phase-2 address sequencer: leaf read addresses plus one write start per destination channel.
// Read/first write pulse 3 cycles after start; each later write start 1 cycle after i_write_done (the only pacing input).
module addr_cal_phase2_param #(
    parameter int C_M_AXI_ADDR_WIDTH = 64,
    parameter int C_XFER_SIZE_WIDTH  = 64,
    parameter int NUM_CH             = 8,
    parameter int SPLIT              = 4,
    parameter int CHANNEL_OFFSET     = 0,
    parameter int CH_STRIDE_LOG2     = 28
) (
    input  logic                                                   aclk,
    input  logic                                                   ap_rst_n,
    input  logic                                                   i_start,
    input  logic                                                   i_pass_parity,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                          i_ptr_ch_0,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                           i_xfer_size_in_bytes,
    input  logic                                                   i_write_done,
    output logic                                                   o_busy,
    output logic                                                   o_read_start,
    output logic [(NUM_CH/2)*SPLIT-1:0][C_M_AXI_ADDR_WIDTH-1:0]    o_read_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]                           o_read_size_in_bytes,
    output logic                                                   o_write_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                          o_write_addr,
    output logic                                                   o_phase_2_done
);

    localparam int AW         = C_M_AXI_ADDR_WIDTH;
    localparam int XW         = C_XFER_SIZE_WIDTH;
    localparam int NUM_SRC    = NUM_CH / 2;
    localparam int NUM_DST    = NUM_CH / 2;
    localparam int NUM_LEAF   = NUM_SRC * SPLIT;
    localparam int SPLIT_LOG2 = $clog2(SPLIT);
    localparam int IDX_W      = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC1 = 2'd1,
        S_CALC2 = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic                            parity_q, parity_d;
    logic [AW-1:0]                   ptr_q, ptr_d;
    logic [XW-1:0]                   size_q, size_d;
    logic [NUM_CH-1:0][AW-1:0]       base_q, base_d;
    logic [XW-1:0]                   seg_q, seg_d;
    logic [NUM_LEAF-1:0][AW-1:0]     read_addr_q, read_addr_d;
    logic [XW-1:0]                   read_size_q, read_size_d;
    logic [NUM_DST-1:0][AW-1:0]      dst_q, dst_d;
    logic [AW-1:0]                   write_addr_q, write_addr_d;
    logic [IDX_W-1:0]                dest_idx_q, dest_idx_d;
    logic                            busy_q, busy_d;
    logic                            read_start_q, read_start_d;
    logic                            write_start_q, write_start_d;
    logic                            done_q, done_d;

    logic [NUM_CH-1:0][AW-1:0]       base_calc;
    logic [XW-1:0]                   seg_calc;
    logic [NUM_LEAF-1:0][AW-1:0]     leaf_calc;
    logic [NUM_DST-1:0][AW-1:0]      dst_calc;
    logic [AW-1:0]                   seg_addr;
    logic [AW-1:0]                   src_addr;
    logic [AW-1:0]                   leaf_acc;

    // First stage: channel bases and per-leaf segment size from the captured inputs.
    always_comb begin
        base_calc = '0;
        seg_calc  = size_q >> SPLIT_LOG2;
        for (int c = 0; c < NUM_CH; c++) begin
            base_calc[c] = ptr_q + (AW'(c + CHANNEL_OFFSET) << CH_STRIDE_LOG2);
        end
    end

    // Second stage: leaves of source s are consecutive seg-sized slices of that channel.
    always_comb begin
        leaf_calc = '0;
        dst_calc  = '0;
        src_addr  = '0;
        leaf_acc  = '0;
        seg_addr  = AW'(seg_q);
        for (int s = 0; s < NUM_SRC; s++) begin
            src_addr = parity_q ? base_q[2*s+1] : base_q[2*s];
            leaf_acc = src_addr;
            for (int k = 0; k < SPLIT; k++) begin
                leaf_calc[s*SPLIT+k] = leaf_acc;
                leaf_acc             = leaf_acc + seg_addr;
            end
        end
        for (int j = 0; j < NUM_DST; j++) begin
            dst_calc[j] = parity_q ? base_q[2*j] : base_q[2*j+1];
        end
    end

    always_comb begin
        state_d       = state_q;
        parity_d      = parity_q;
        ptr_d         = ptr_q;
        size_d        = size_q;
        base_d        = base_q;
        seg_d         = seg_q;
        read_addr_d   = read_addr_q;
        read_size_d   = read_size_q;
        dst_d         = dst_q;
        write_addr_d  = write_addr_q;
        dest_idx_d    = dest_idx_q;
        busy_d        = busy_q;
        read_start_d  = 1'b0;
        write_start_d = 1'b0;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    parity_d = i_pass_parity;
                    ptr_d    = i_ptr_ch_0;
                    size_d   = i_xfer_size_in_bytes;
                    busy_d   = 1'b1;
                    state_d  = S_CALC1;
                end
            end
            S_CALC1: begin
                base_d  = base_calc;
                seg_d   = seg_calc;
                state_d = S_CALC2;
            end
            S_CALC2: begin
                read_addr_d   = leaf_calc;
                read_size_d   = seg_q;
                dst_d         = dst_calc;
                write_addr_d  = dst_calc[0];
                dest_idx_d    = '0;
                read_start_d  = 1'b1;
                write_start_d = 1'b1;
                state_d       = S_RUN;
            end
            S_RUN: begin
                if (i_write_done) begin
                    if (dest_idx_q == IDX_W'(NUM_DST - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        dest_idx_d    = dest_idx_q + IDX_W'(1);
                        write_start_d = 1'b1;
                        // Select by compare so the index never leaves dst_q's range.
                        for (int j = 0; j < NUM_DST; j++) begin
                            if (IDX_W'(j) == dest_idx_d) begin
                                write_addr_d = dst_q[j];
                            end
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q       <= S_IDLE;
            parity_q      <= 1'b0;
            ptr_q         <= '0;
            size_q        <= '0;
            base_q        <= '0;
            seg_q         <= '0;
            read_addr_q   <= '0;
            read_size_q   <= '0;
            dst_q         <= '0;
            write_addr_q  <= '0;
            dest_idx_q    <= '0;
            busy_q        <= 1'b0;
            read_start_q  <= 1'b0;
            write_start_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            parity_q      <= parity_d;
            ptr_q         <= ptr_d;
            size_q        <= size_d;
            base_q        <= base_d;
            seg_q         <= seg_d;
            read_addr_q   <= read_addr_d;
            read_size_q   <= read_size_d;
            dst_q         <= dst_d;
            write_addr_q  <= write_addr_d;
            dest_idx_q    <= dest_idx_d;
            busy_q        <= busy_d;
            read_start_q  <= read_start_d;
            write_start_q <= write_start_d;
            done_q        <= done_d;
        end
    end

    assign o_busy               = busy_q;
    assign o_read_start         = read_start_q;
    assign o_read_addr          = read_addr_q;
    assign o_read_size_in_bytes = read_size_q;
    assign o_write_start        = write_start_q;
    assign o_write_addr         = write_addr_q;
    assign o_phase_2_done       = done_q;

endmodule

// File: tb/tb_addr_cal_phase2_param.sv
// Directed bench: default instance (8 ch, split 4) and an offset/split-2 instance.
module tb_addr_cal_phase2_param;

    logic        clk;
    logic        ap_rst_n;
    logic        parity;
    logic [63:0] ptr;
    logic [63:0] size;

    logic        start_a, wdone_a;
    logic        busy_a, rstart_a, wstart_a, done_a;
    logic [15:0][63:0] raddr_a;
    logic [63:0] rsize_a, waddr_a;

    logic        start_b, wdone_b;
    logic        busy_b, rstart_b, wstart_b, done_b;
    logic [7:0][63:0] raddr_b;
    logic [63:0] rsize_b, waddr_b;

    logic [63:0] exp_w [4];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addr_cal_phase2_param dut_a (
        .aclk(clk), .ap_rst_n(ap_rst_n), .i_start(start_a), .i_pass_parity(parity),
        .i_ptr_ch_0(ptr), .i_xfer_size_in_bytes(size), .i_write_done(wdone_a),
        .o_busy(busy_a), .o_read_start(rstart_a), .o_read_addr(raddr_a),
        .o_read_size_in_bytes(rsize_a), .o_write_start(wstart_a), .o_write_addr(waddr_a),
        .o_phase_2_done(done_a)
    );

    addr_cal_phase2_param #(.CHANNEL_OFFSET(8), .SPLIT(2)) dut_b (
        .aclk(clk), .ap_rst_n(ap_rst_n), .i_start(start_b), .i_pass_parity(parity),
        .i_ptr_ch_0(ptr), .i_xfer_size_in_bytes(size), .i_write_done(wdone_b),
        .o_busy(busy_b), .o_read_start(rstart_b), .o_read_addr(raddr_b),
        .o_read_size_in_bytes(rsize_b), .o_write_start(wstart_b), .o_write_addr(waddr_b),
        .o_phase_2_done(done_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b1;
        #2 ap_rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy_a); end
        checks++; if (rstart_a !== 1'b0) begin failures++; $display("FAIL reset_rstart got=%h exp=0", rstart_a); end
        checks++; if (wstart_a !== 1'b0) begin failures++; $display("FAIL reset_wstart got=%h exp=0", wstart_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done got=%h exp=0", done_a); end
        checks++; if (raddr_a !== '0) begin failures++; $display("FAIL reset_raddr got=%h exp=0", raddr_a); end
        checks++; if (rsize_a !== 64'h0) begin failures++; $display("FAIL reset_rsize got=%h exp=0", rsize_a); end
        checks++; if (waddr_a !== 64'h0) begin failures++; $display("FAIL reset_waddr got=%h exp=0", waddr_a); end
        checks++; if (busy_b !== 1'b0 || waddr_b !== 64'h0) begin failures++; $display("FAIL reset_b got busy=%h waddr=%h exp 0", busy_b, waddr_b); end
        step();
        step();
        ap_rst_n = 1'b1;
        step();
    endtask

    task automatic test_parity0();
        parity = 1'b0; ptr = 64'h1_0000_0000; size = 64'h0400_0000;
        exp_w[0] = 64'h1_1000_0000; exp_w[1] = 64'h1_3000_0000;
        exp_w[2] = 64'h1_5000_0000; exp_w[3] = 64'h1_7000_0000;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL p0_busy_t1 got=%h exp=1", busy_a); end
        checks++; if (rstart_a !== 1'b0) begin failures++; $display("FAIL p0_rstart_t1 got=%h exp=0", rstart_a); end
        step();
        checks++; if (rstart_a !== 1'b0 || wstart_a !== 1'b0) begin failures++; $display("FAIL p0_early_pulse got r=%h w=%h exp 0", rstart_a, wstart_a); end
        step();
        checks++; if (rstart_a !== 1'b1) begin failures++; $display("FAIL p0_rstart got=%h exp=1", rstart_a); end
        checks++; if (wstart_a !== 1'b1) begin failures++; $display("FAIL p0_wstart0 got=%h exp=1", wstart_a); end
        checks++; if (rsize_a !== 64'h0100_0000) begin failures++; $display("FAIL p0_rsize got=%h exp=%h", rsize_a, 64'h0100_0000); end
        checks++; if (raddr_a[0] !== 64'h1_0000_0000) begin failures++; $display("FAIL p0_leaf0 got=%h exp=%h", raddr_a[0], 64'h1_0000_0000); end
        checks++; if (raddr_a[1] !== 64'h1_0100_0000) begin failures++; $display("FAIL p0_leaf1 got=%h exp=%h", raddr_a[1], 64'h1_0100_0000); end
        checks++; if (raddr_a[2] !== 64'h1_0200_0000) begin failures++; $display("FAIL p0_leaf2 got=%h exp=%h", raddr_a[2], 64'h1_0200_0000); end
        checks++; if (raddr_a[3] !== 64'h1_0300_0000) begin failures++; $display("FAIL p0_leaf3 got=%h exp=%h", raddr_a[3], 64'h1_0300_0000); end
        checks++; if (raddr_a[4] !== 64'h1_2000_0000) begin failures++; $display("FAIL p0_leaf4 got=%h exp=%h", raddr_a[4], 64'h1_2000_0000); end
        checks++; if (raddr_a[15] !== 64'h1_6300_0000) begin failures++; $display("FAIL p0_leaf15 got=%h exp=%h", raddr_a[15], 64'h1_6300_0000); end
        checks++; if (waddr_a !== exp_w[0]) begin failures++; $display("FAIL p0_waddr0 got=%h exp=%h", waddr_a, exp_w[0]); end
        // Inputs changed mid-run must not disturb the captured values.
        ptr = 64'hDEAD_0000_0000; size = 64'h0; parity = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            checks++; if (wstart_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL p0_gap%0d got w=%h busy=%h exp w=0 busy=1", j, wstart_a, busy_a); end
            wdone_a = 1'b1;
            step();
            wdone_a = 1'b0;
            if (j < 3) begin
                checks++; if (wstart_a !== 1'b1 || waddr_a !== exp_w[j+1] || done_a !== 1'b0) begin failures++; $display("FAIL p0_step%0d got w=%h addr=%h done=%h exp w=1 addr=%h done=0", j, wstart_a, waddr_a, done_a, exp_w[j+1]); end
            end else begin
                checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || wstart_a !== 1'b0) begin failures++; $display("FAIL p0_done got done=%h busy=%h w=%h exp 1 0 0", done_a, busy_a, wstart_a); end
            end
        end
        step();
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL p0_done_len got=%h exp=0", done_a); end
        checks++; if (rsize_a !== 64'h0100_0000 || raddr_a[1] !== 64'h1_0100_0000) begin failures++; $display("FAIL p0_hold got size=%h leaf1=%h", rsize_a, raddr_a[1]); end
    endtask

    task automatic test_parity1();
        parity = 1'b1; ptr = 64'h1_0000_0000; size = 64'h0400_0000;
        exp_w[0] = 64'h1_0000_0000; exp_w[1] = 64'h1_2000_0000;
        exp_w[2] = 64'h1_4000_0000; exp_w[3] = 64'h1_6000_0000;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        checks++; if (rstart_a !== 1'b1) begin failures++; $display("FAIL p1_rstart got=%h exp=1", rstart_a); end
        checks++; if (raddr_a[0] !== 64'h1_1000_0000) begin failures++; $display("FAIL p1_leaf0 got=%h exp=%h", raddr_a[0], 64'h1_1000_0000); end
        checks++; if (raddr_a[5] !== 64'h1_3100_0000) begin failures++; $display("FAIL p1_leaf5 got=%h exp=%h", raddr_a[5], 64'h1_3100_0000); end
        checks++; if (waddr_a !== exp_w[0]) begin failures++; $display("FAIL p1_waddr0 got=%h exp=%h", waddr_a, exp_w[0]); end
        // Write-done coincident with each write-start pulse.
        for (int j = 0; j < 4; j++) begin
            wdone_a = 1'b1;
            step();
            wdone_a = 1'b0;
            if (j < 3) begin
                checks++; if (wstart_a !== 1'b1 || waddr_a !== exp_w[j+1]) begin failures++; $display("FAIL p1_step%0d got w=%h addr=%h exp w=1 addr=%h", j, wstart_a, waddr_a, exp_w[j+1]); end
            end else begin
                checks++; if (done_a !== 1'b1 || busy_a !== 1'b0 || waddr_a !== exp_w[3]) begin failures++; $display("FAIL p1_done got done=%h busy=%h addr=%h exp 1 0 %h", done_a, busy_a, waddr_a, exp_w[3]); end
            end
        end
        step();
        checks++; if (done_a !== 1'b0 || wstart_a !== 1'b0) begin failures++; $display("FAIL p1_after got done=%h w=%h exp 0 0", done_a, wstart_a); end
    endtask

    task automatic test_offset_split();
        parity = 1'b0; ptr = 64'h0; size = 64'h200;
        exp_w[0] = 64'h9000_0000; exp_w[1] = 64'hB000_0000;
        exp_w[2] = 64'hD000_0000; exp_w[3] = 64'hF000_0000;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        wdone_b = 1'b1;
        step();
        step();
        wdone_b = 1'b0;
        checks++; if (rstart_b !== 1'b1 || wstart_b !== 1'b1) begin failures++; $display("FAIL os_pulse got r=%h w=%h exp 1 1", rstart_b, wstart_b); end
        checks++; if (raddr_b[0] !== 64'h8000_0000) begin failures++; $display("FAIL os_leaf0 got=%h exp=%h", raddr_b[0], 64'h8000_0000); end
        checks++; if (raddr_b[1] !== 64'h8000_0100) begin failures++; $display("FAIL os_leaf1 got=%h exp=%h", raddr_b[1], 64'h8000_0100); end
        checks++; if (raddr_b[2] !== 64'hA000_0000) begin failures++; $display("FAIL os_leaf2 got=%h exp=%h", raddr_b[2], 64'hA000_0000); end
        checks++; if (rsize_b !== 64'h100) begin failures++; $display("FAIL os_rsize got=%h exp=100", rsize_b); end
        checks++; if (waddr_b !== exp_w[0]) begin failures++; $display("FAIL os_waddr0 got=%h exp=%h", waddr_b, exp_w[0]); end
        step();
        checks++; if (wstart_b !== 1'b0 || done_b !== 1'b0 || busy_b !== 1'b1 || waddr_b !== exp_w[0]) begin failures++; $display("FAIL os_ignored_done got w=%h done=%h busy=%h addr=%h", wstart_b, done_b, busy_b, waddr_b); end
        for (int j = 0; j < 4; j++) begin
            wdone_b = 1'b1;
            step();
            wdone_b = 1'b0;
            if (j < 3) begin
                checks++; if (wstart_b !== 1'b1 || waddr_b !== exp_w[j+1]) begin failures++; $display("FAIL os_step%0d got w=%h addr=%h exp w=1 addr=%h", j, wstart_b, waddr_b, exp_w[j+1]); end
            end else begin
                checks++; if (done_b !== 1'b1 || busy_b !== 1'b0) begin failures++; $display("FAIL os_done got done=%h busy=%h exp 1 0", done_b, busy_b); end
            end
        end
        step();
    endtask

    task automatic test_ignore_start_and_reset();
        int dones;
        parity = 1'b0; ptr = 64'h1_0000_0000; size = 64'h0400_0000;
        exp_w[0] = 64'h1_1000_0000; exp_w[1] = 64'h1_3000_0000;
        exp_w[2] = 64'h1_5000_0000; exp_w[3] = 64'h1_7000_0000;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        step();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        checks++; if (rstart_a !== 1'b0 || wstart_a !== 1'b0 || busy_a !== 1'b1) begin failures++; $display("FAIL ig_start got r=%h w=%h busy=%h exp 0 0 1", rstart_a, wstart_a, busy_a); end
        dones = 0;
        for (int j = 0; j < 4; j++) begin
            wdone_a = 1'b1;
            step();
            wdone_a = 1'b0;
            if (done_a === 1'b1) dones++;
            if (j < 3) begin
                checks++; if (wstart_a !== 1'b1 || waddr_a !== exp_w[j+1]) begin failures++; $display("FAIL ig_step%0d got w=%h addr=%h exp w=1 addr=%h", j, wstart_a, waddr_a, exp_w[j+1]); end
            end
        end
        for (int j = 0; j < 4; j++) begin
            step();
            if (done_a === 1'b1) dones++;
        end
        checks++; if (dones !== 1) begin failures++; $display("FAIL ig_done_count got=%0d exp=1", dones); end

        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        wdone_a = 1'b1;
        step();
        step();
        wdone_a = 1'b0;
        #2 ap_rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || wstart_a !== 1'b0 || waddr_a !== 64'h0 || rsize_a !== 64'h0 || raddr_a[0] !== 64'h0) begin failures++; $display("FAIL mid_reset got busy=%h w=%h addr=%h size=%h", busy_a, wstart_a, waddr_a, rsize_a); end
        #2 ap_rst_n = 1'b1;
        dones = 0;
        for (int j = 0; j < 4; j++) begin
            step();
            if (done_a === 1'b1 || busy_a === 1'b1) dones++;
        end
        checks++; if (dones !== 0) begin failures++; $display("FAIL post_reset_idle got=%0d exp=0", dones); end
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        checks++; if (wstart_a !== 1'b1 || waddr_a !== exp_w[0] || raddr_a[0] !== 64'h1_0000_0000) begin failures++; $display("FAIL fresh_run got w=%h addr=%h leaf0=%h exp w=1 addr=%h", wstart_a, waddr_a, raddr_a[0], exp_w[0]); end
        for (int j = 0; j < 4; j++) begin
            wdone_a = 1'b1;
            step();
            wdone_a = 1'b0;
        end
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL fresh_done got=%h exp=1", done_a); end
        step();
    endtask

    task automatic test_back_to_back();
        parity = 1'b0; ptr = 64'h1_0000_0000; size = 64'h0400_0000;
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        for (int j = 0; j < 4; j++) begin
            wdone_a = 1'b1;
            step();
            wdone_a = 1'b0;
        end
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL b2b_done1 got=%h exp=1", done_a); end
        start_a = 1'b1; size = 64'h0800_0000; ptr = 64'h2_0000_0000;
        step();
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin failures++; $display("FAIL b2b_accept got busy=%h done=%h exp 1 0", busy_a, done_a); end
        step();
        step();
        checks++; if (rstart_a !== 1'b1 || rsize_a !== 64'h0200_0000) begin failures++; $display("FAIL b2b_rsize got r=%h size=%h exp 1 %h", rstart_a, rsize_a, 64'h0200_0000); end
        checks++; if (raddr_a[1] !== 64'h2_0200_0000 || raddr_a[4] !== 64'h2_2000_0000) begin failures++; $display("FAIL b2b_leaves got l1=%h l4=%h", raddr_a[1], raddr_a[4]); end
        checks++; if (waddr_a !== 64'h2_1000_0000) begin failures++; $display("FAIL b2b_waddr got=%h exp=%h", waddr_a, 64'h2_1000_0000); end
        for (int j = 0; j < 4; j++) begin
            wdone_a = 1'b1;
            step();
            wdone_a = 1'b0;
        end
        checks++; if (done_a !== 1'b1 || waddr_a !== 64'h2_7000_0000) begin failures++; $display("FAIL b2b_done2 got done=%h addr=%h exp 1 %h", done_a, waddr_a, 64'h2_7000_0000); end
        step();
    endtask

    initial begin
        ap_rst_n = 1'b1;
        start_a = 1'b0; wdone_a = 1'b0;
        start_b = 1'b0; wdone_b = 1'b0;
        parity = 1'b0; ptr = 64'h0; size = 64'h0;
        test_reset();
        test_parity0();
        test_parity1();
        test_offset_split();
        test_ignore_start_and_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
